// File: rtl/hazard_controller_pkg.sv
// Shared types for the decode-stage hazard controller: scoreboard entry and FSM state.
// No logic; widths here fix the scoreboard entry layout.
package hazard_controller_pkg;

    localparam int HZ_ADDR_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [HZ_ADDR_W-1:0] waddr;
        logic                 regwrite;
        logic                 setflags;
    } hz_entry_t;

    typedef enum logic {
        HZ_RUN,
        HZ_FLUSH
    } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: DEPTH-stage shift register (EX..WB) plus source comparators.
// Shifts every cycle with no hold; match outputs are combinational from current entries.
module hazard_scoreboard
    import hazard_controller_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int ADDR_W   = HZ_ADDR_W,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  hz_entry_t         load_entry,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              match_a,
    output logic              match_b,
    output logic              flags_pending,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    hz_entry_t entries [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else begin
            entries[0] <= load ? load_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

    // The WB entry is still compared: the regfile has no write-through bypass.
    always_comb begin
        match_a       = 1'b0;
        match_b       = 1'b0;
        flags_pending = 1'b0;
        empty         = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (entries[k].valid) begin
                empty = 1'b0;
                if (entries[k].regwrite && entries[k].waddr == addr_a) match_a = 1'b1;
                if (entries[k].regwrite && entries[k].waddr == addr_b) match_b = 1'b1;
                if (entries[k].setflags) flags_pending = 1'b1;
            end
        end
        if (addr_a == ZERO_ADDR) match_a = 1'b0;
        if (addr_b == ZERO_ADDR) match_b = 1'b0;
    end

endmodule

// File: rtl/hazard_controller.sv
// Decode issue/stall/flush sequencer for the in-order pipeline with RAW scoreboard.
// Zero added latency (hazards stall same cycle); flush outranks stall, reset outranks both.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int ADDR_W       = HZ_ADDR_W,
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int ZERO_REG     = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic              dec_use_a,
    input  logic [ADDR_W-1:0] dec_addr_a,
    input  logic              dec_use_b,
    input  logic [ADDR_W-1:0] dec_addr_b,
    input  logic              dec_uses_flags,
    input  logic              dec_regwrite,
    input  logic [ADDR_W-1:0] dec_write_addr,
    input  logic              dec_setflags,
    input  logic              branch_taken,
    output logic              issue,
    output logic              stall,
    output logic              flush,
    output logic              pipe_empty,
    output logic [31:0]       stall_count
);

    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    hz_state_t      state;
    logic [CNT_W-1:0] cnt;
    hz_entry_t      new_entry;
    logic           match_a;
    logic           match_b;
    logic           flags_pending;
    logic           sb_empty;
    logic           hazard;

    assign new_entry = '{valid: 1'b1, waddr: dec_write_addr,
                         regwrite: dec_regwrite, setflags: dec_setflags};

    hazard_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .load          (issue),
        .load_entry    (new_entry),
        .addr_a        (dec_addr_a),
        .addr_b        (dec_addr_b),
        .match_a       (match_a),
        .match_b       (match_b),
        .flags_pending (flags_pending),
        .empty         (sb_empty)
    );

    assign hazard = dec_valid & ((dec_use_a & match_a) |
                                 (dec_use_b & match_b) |
                                 (dec_uses_flags & flags_pending));

    // Outputs are forced quiet while reset is held so nothing leaks into decode.
    always_comb begin
        issue = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        if (rst) begin
            if (state == HZ_FLUSH || branch_taken) begin
                flush = 1'b1;
            end else begin
                stall = hazard;
                issue = dec_valid & ~hazard;
            end
        end
    end

    assign pipe_empty = ~rst | sb_empty;

    // branch_taken is ignored in FLUSH: only bubbles can occupy EX there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (branch_taken && FLUSH_CYCLES > 1) begin
                        cnt   <= CNT_W'(FLUSH_CYCLES - 2);
                        state <= HZ_FLUSH;
                    end
                end
                HZ_FLUSH: begin
                    if (cnt == '0) state <= HZ_RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: reset, RAW stalls, zero register, flag hazards, flush, reset mid-flush.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_use_a;
    logic [4:0]  dec_addr_a;
    logic        dec_use_b;
    logic [4:0]  dec_addr_b;
    logic        dec_uses_flags;
    logic        dec_regwrite;
    logic [4:0]  dec_write_addr;
    logic        dec_setflags;
    logic        branch_taken;
    logic        issue;
    logic        stall;
    logic        flush;
    logic        pipe_empty;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_controller #(
        .ADDR_W(5), .DEPTH(3), .FLUSH_CYCLES(2), .ZERO_REG(31)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_use_a      (dec_use_a),
        .dec_addr_a     (dec_addr_a),
        .dec_use_b      (dec_use_b),
        .dec_addr_b     (dec_addr_b),
        .dec_uses_flags (dec_uses_flags),
        .dec_regwrite   (dec_regwrite),
        .dec_write_addr (dec_write_addr),
        .dec_setflags   (dec_setflags),
        .branch_taken   (branch_taken),
        .issue          (issue),
        .stall          (stall),
        .flush          (flush),
        .pipe_empty     (pipe_empty),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_use_a = 0; dec_addr_a = 0; dec_use_b = 0; dec_addr_b = 0;
        dec_uses_flags = 0; dec_regwrite = 0; dec_write_addr = 0; dec_setflags = 0;
        branch_taken = 0;
    endtask

    task automatic write_reg(input logic [4:0] wa);
        idle();
        dec_valid = 1; dec_regwrite = 1; dec_write_addr = wa;
    endtask

    task automatic read_a(input logic [4:0] ra);
        idle();
        dec_valid = 1; dec_use_a = 1; dec_addr_a = ra;
    endtask

    task automatic check_ctl(input string tag, input logic exp_issue, input logic exp_stall, input logic exp_flush);
        #2;
        check_val({tag, ".issue"}, {31'd0, issue}, {31'd0, exp_issue});
        check_val({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        check_val({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
    endtask

    initial begin
        idle();
        rst = 0;
        #1;
        // 1. Reset with a valid decode presented
        for (int i = 0; i < 2; i++) begin
            write_reg(5'd3);
            check_ctl("rst", 0, 0, 0);
            check_val("rst.empty", {31'd0, pipe_empty}, 32'd1);
            tick();
        end
        check_val("rst.count", stall_count, 32'd0);
        rst = 1;

        // 2. RAW on source A: three stalls, issue in the fourth cycle
        write_reg(5'd3);
        check_ctl("raw.c0", 1, 0, 0);
        tick();
        read_a(5'd3);
        for (int c = 1; c <= 3; c++) begin
            check_ctl($sformatf("raw.c%0d", c), 0, 1, 0);
            tick();
        end
        check_ctl("raw.c4", 1, 0, 0);
        check_val("raw.count", stall_count, 32'd3);
        tick();
        idle();
        repeat (3) tick();
        #2 check_val("raw.drain_empty", {31'd0, pipe_empty}, 32'd1);

        // 3. Zero register never creates a hazard
        write_reg(5'd31);
        check_ctl("zr.w", 1, 0, 0);
        tick();
        idle();
        dec_valid = 1; dec_use_b = 1; dec_addr_b = 5'd31;
        check_ctl("zr.r", 1, 0, 0);
        check_val("zr.count", stall_count, 32'd3);
        tick();

        // 4. Flag RAW, then a flag reader with only non-flag writers in flight
        idle();
        dec_valid = 1; dec_setflags = 1;
        check_ctl("fl.set", 1, 0, 0);
        tick();
        idle();
        dec_valid = 1; dec_uses_flags = 1;
        for (int c = 1; c <= 3; c++) begin
            check_ctl($sformatf("fl.c%0d", c), 0, 1, 0);
            tick();
        end
        check_ctl("fl.c4", 1, 0, 0);
        tick();
        check_ctl("fl.nopend", 1, 0, 0);
        check_val("fl.count", stall_count, 32'd6);
        tick();
        idle();
        repeat (3) tick();

        // 5. Taken branch while decode has a hazard; the squashed insn writes X9
        write_reg(5'd7);
        check_ctl("br.c0", 1, 0, 0);
        tick();
        read_a(5'd7);
        dec_regwrite = 1; dec_write_addr = 5'd9; branch_taken = 1;
        check_ctl("br.c1", 0, 0, 1);
        tick();
        branch_taken = 0;
        check_ctl("br.c2", 0, 0, 1);
        tick();
        check_ctl("br.c3", 0, 1, 0);
        tick();
        // X7 has left WB; a squashed X9 write would still be in flight here
        idle();
        dec_valid = 1; dec_use_a = 1; dec_addr_a = 5'd7; dec_use_b = 1; dec_addr_b = 5'd9;
        check_ctl("br.c4", 1, 0, 0);
        check_val("br.count", stall_count, 32'd7);
        tick();

        // 6. Reset during the flush cycle
        write_reg(5'd4);
        check_ctl("rf.w", 1, 0, 0);
        tick();
        idle();
        branch_taken = 1;
        check_ctl("rf.br", 0, 0, 1);
        tick();
        branch_taken = 0;
        rst = 0;
        check_ctl("rf.inrst", 0, 0, 0);
        tick();
        rst = 1;
        check_ctl("rf.after", 0, 0, 0);
        check_val("rf.empty", {31'd0, pipe_empty}, 32'd1);
        check_val("rf.count", stall_count, 32'd0);
        tick();
        read_a(5'd4);
        check_ctl("rf.read", 1, 0, 0);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: bench did not complete, expected completion within 20000 time units");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
